// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the in-order pipeline sequencer: stage indices,
// the default stage payload layout and a saturating counter increment.
package pipeline_pkg;

  localparam int STG_FETCH   = 0;
  localparam int STG_DECODE  = 1;
  localparam int STG_EXECUTE = 2;
  localparam int STG_MEM     = 3;
  localparam int STG_WB      = 4;

  localparam int PERF_CNT_W = 32;

  // pc sits in the low word so a payload's PC is payload[31:0]
  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] result;
    logic [31:0] instr;
    logic [31:0] pc;
  } stage_status_t;

  localparam int PAYLOAD_W_DEFAULT = $bits(stage_status_t);

  typedef struct packed {
    logic [PERF_CNT_W-1:0] cycle;
    logic [PERF_CNT_W-1:0] retire;
    logic [PERF_CNT_W-1:0] stall;
    logic [PERF_CNT_W-1:0] flush;
  } perf_counters_t;

  // Increments val, sticking at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One inter-stage register: payload plus valid bit, with load enable and a
// bubble input that clears the slot regardless of load.
module pipe_stage_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         bubble,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= valid_in;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control for the in-order core: PC, inter-stage registers, stall and
// bubble propagation, redirect flush, ebreak halt/drain and perf counters.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int              NUM_STAGES     = 5,
  parameter int              PAYLOAD_W      = PAYLOAD_W_DEFAULT,
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int              PC_STEP        = 4,
  parameter int              REDIRECT_STAGE = 2,
  parameter int              CNT_W          = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [(NUM_STAGES-1)*PAYLOAD_W-1:0] stage_out_data,
  input  logic [NUM_STAGES-1:0]               stage_ready,
  input  logic                                redirect,
  input  logic [XLEN-1:0]                     redirect_pc,
  input  logic                                halt_req,
  output logic [XLEN-1:0]                     pc,
  output logic [(NUM_STAGES-1)*PAYLOAD_W-1:0] stage_in_data,
  output logic [NUM_STAGES-2:0]               stage_in_valid,
  output logic                                flush,
  output logic                                halted,
  output logic [CNT_W-1:0]                    cycle_cnt,
  output logic [CNT_W-1:0]                    retire_cnt,
  output logic [CNT_W-1:0]                    stall_cnt,
  output logic [CNT_W-1:0]                    flush_cnt
);

  localparam int NR = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] adv;
  logic [NR-1:0]         src_valid;
  logic                  pc_adv;
  logic                  halt_take;

  // adv[k]: every stage from k to writeback can complete; adv[0] also covers fetch
  always_comb begin
    adv = '0;
    adv[NUM_STAGES-1] = stage_ready[NUM_STAGES-1];
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      adv[k] = adv[k+1] & stage_ready[k];
    end
  end

  assign src_valid = {stage_in_valid[NR-2:0], ~halted};
  assign pc_adv    = adv[0] & ~halted;
  assign flush     = redirect & stage_in_valid[REDIRECT_STAGE-1] & adv[REDIRECT_STAGE+1];
  assign halt_take = halt_req & stage_in_valid[NUM_STAGES-3] & adv[NUM_STAGES-1];

  for (genvar k = 1; k <= NR; k++) begin : g_reg
    localparam bit FLUSHABLE = (k <= REDIRECT_STAGE);
    pipe_stage_reg #(.W(PAYLOAD_W)) u_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (adv[k]),
      .bubble   (flush & FLUSHABLE),
      .valid_in (src_valid[k-1] & stage_ready[k-1]),
      .data_in  (stage_out_data[(k-1)*PAYLOAD_W +: PAYLOAD_W]),
      .valid    (stage_in_valid[k-1]),
      .data     (stage_in_data[(k-1)*PAYLOAD_W +: PAYLOAD_W])
    );
  end

  // A redirect overrides the halt freeze; halted itself only clears on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      if (flush) begin
        pc <= redirect_pc;
      end else if (pc_adv) begin
        pc <= pc + XLEN'(PC_STEP);
      end
      if (halt_take) begin
        halted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      cycle_cnt <= CNT_W'(sat_inc(64'(cycle_cnt), CNT_W));
      if (stage_in_valid[NR-1] & stage_ready[NUM_STAGES-1]) begin
        retire_cnt <= CNT_W'(sat_inc(64'(retire_cnt), CNT_W));
      end
      if (~pc_adv & ~halted & ~flush) begin
        stall_cnt <= CNT_W'(sat_inc(64'(stall_cnt), CNT_W));
      end
      if (flush) begin
        flush_cnt <= CNT_W'(sat_inc(64'(flush_cnt), CNT_W));
      end
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer; stages are modelled as pass-through
// so each payload carries the PC it was fetched at.
module tb_pipeline_sequencer;

  localparam int N  = 5;
  localparam int W  = 128;
  localparam int XL = 32;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [(N-1)*W-1:0] stage_out_data;
  logic [(N-1)*W-1:0] stage_in_data;
  logic [N-1:0]      stage_ready;
  logic              redirect;
  logic [XL-1:0]     redirect_pc;
  logic              halt_req;
  logic [XL-1:0]     pc;
  logic [N-2:0]      stage_in_valid;
  logic              flush;
  logic              halted;
  logic [CW-1:0]     cycle_cnt, retire_cnt, stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(
    .NUM_STAGES(N), .PAYLOAD_W(W), .XLEN(XL), .RESET_PC(32'h0),
    .PC_STEP(4), .REDIRECT_STAGE(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stage_out_data(stage_out_data),
    .stage_ready(stage_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .pc(pc), .stage_in_data(stage_in_data),
    .stage_in_valid(stage_in_valid), .flush(flush), .halted(halted),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  assign stage_out_data[W-1:0] = {96'h0, pc};
  for (genvar k = 1; k < N - 1; k++) begin : g_stage
    assign stage_out_data[k*W +: W] = stage_in_data[(k-1)*W +: W];
  end

  function automatic logic [31:0] rpc(input int k);
    return stage_in_data[(k-1)*W +: 32];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stage_ready = '1; redirect = 1'b1; redirect_pc = 32'h80; halt_req = 1'b0;
    rst_n = 1'b0;
    tick(2);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (stage_in_valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %b expected %b", stage_in_valid, 4'h0); end
    checks++; if (stage_in_data !== '0) begin errors++; $display("FAIL reset_data: got nonzero payload expected zero"); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if ({cycle_cnt, retire_cnt, stall_cnt, flush_cnt} !== 32'h0) begin errors++; $display("FAIL reset_counters: got %h expected 0", {cycle_cnt, retire_cnt, stall_cnt, flush_cnt}); end
    redirect = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [3:0] ev;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      ev = (i >= 4) ? 4'hF : 4'((1 << i) - 1);
      checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL fill_pc[%0d]: got %h expected %h", i, pc, 32'(4 * i)); end
      checks++; if (stage_in_valid !== ev) begin errors++; $display("FAIL fill_valid[%0d]: got %b expected %b", i, stage_in_valid, ev); end
    end
    checks++; if (rpc(4) !== 32'h8) begin errors++; $display("FAIL fill_r4_pc: got %h expected %h", rpc(4), 32'h8); end
    checks++; if (retire_cnt !== 8'd2) begin errors++; $display("FAIL fill_retire: got %0d expected 2", retire_cnt); end
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL fill_stall: got %0d expected 0", stall_cnt); end
    checks++; if (cycle_cnt !== 8'd6) begin errors++; $display("FAIL fill_cycle: got %0d expected 6", cycle_cnt); end
  endtask

  task automatic test_stall();
    logic [3:0] ev [3] = '{4'b1011, 4'b0011, 4'b0011};
    stage_ready = 5'b11011;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (pc !== 32'h18) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, 32'h18); end
      checks++; if (stage_in_valid !== ev[i]) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected %b", i, stage_in_valid, ev[i]); end
      checks++; if ({rpc(1), rpc(2)} !== {32'h14, 32'h10}) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%h expected 14/10", i, rpc(1), rpc(2)); end
    end
    checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
    stage_ready = '1;
    tick(1);
    checks++; if (stage_in_valid !== 4'b0111) begin errors++; $display("FAIL stall_resume_valid: got %b expected 0111", stage_in_valid); end
    checks++; if (rpc(3) !== 32'h10) begin errors++; $display("FAIL stall_resume_r3: got %h expected %h", rpc(3), 32'h10); end
    tick(1);
    checks++; if (rpc(4) !== 32'h10) begin errors++; $display("FAIL stall_order_r4: got %h expected %h", rpc(4), 32'h10); end
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL stall_resume_pc: got %h expected %h", pc, 32'h20); end
    checks++; if (retire_cnt !== 8'd4) begin errors++; $display("FAIL stall_retire: got %0d expected 4", retire_cnt); end
    checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL stall_cnt_after: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL redir_flush: got %b expected 1", flush); end
    tick(1);
    redirect = 1'b0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL redir_flush_drop: got %b expected 0", flush); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL redir_pc: got %h expected %h", pc, 32'h100); end
    checks++; if (stage_in_valid !== 4'b1100) begin errors++; $display("FAIL redir_valid: got %b expected 1100", stage_in_valid); end
    checks++; if (rpc(3) !== 32'h18) begin errors++; $display("FAIL redir_r3_branch: got %h expected %h", rpc(3), 32'h18); end
    checks++; if (rpc(1) !== 32'h0) begin errors++; $display("FAIL redir_r1_zeroed: got %h expected 0", rpc(1)); end
    checks++; if (flush_cnt !== 8'd1) begin errors++; $display("FAIL redir_flush_cnt: got %0d expected 1", flush_cnt); end
    tick(1);
    checks++; if (stage_in_valid !== 4'b1001) begin errors++; $display("FAIL redir_after_valid: got %b expected 1001", stage_in_valid); end
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL redir_after_pc: got %h expected %h", pc, 32'h104); end
  endtask

  task automatic test_redirect_stall();
    tick(1);
    checks++; if (stage_in_valid !== 4'b0011) begin errors++; $display("FAIL rstall_pre_valid: got %b expected 0011", stage_in_valid); end
    stage_ready = 5'b10111; redirect = 1'b1; redirect_pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstall_noflush[%0d]: got %b expected 0", i, flush); end
      tick(1);
      checks++; if (pc !== 32'h108) begin errors++; $display("FAIL rstall_pc[%0d]: got %h expected %h", i, pc, 32'h108); end
    end
    checks++; if (stall_cnt !== 8'd5) begin errors++; $display("FAIL rstall_stall_cnt: got %0d expected 5", stall_cnt); end
    stage_ready = '1;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rstall_flush: got %b expected 1", flush); end
    tick(1);
    redirect = 1'b0;
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL rstall_target: got %h expected %h", pc, 32'h200); end
    checks++; if (flush_cnt !== 8'd2) begin errors++; $display("FAIL rstall_flush_cnt: got %0d expected 2", flush_cnt); end
    checks++; if ({stage_in_valid[2], rpc(3)} !== {1'b1, 32'h100}) begin errors++; $display("FAIL rstall_r3: got %b/%h expected 1/100", stage_in_valid[2], rpc(3)); end
  endtask

  task automatic test_halt();
    logic [3:0] ev [2] = '{4'b1000, 4'b0000};
    do_reset();
    stage_ready = '1;
    tick(4);
    checks++; if ({stage_in_valid, pc} !== {4'hF, 32'h10}) begin errors++; $display("FAIL halt_pre: got %b/%h expected 1111/10", stage_in_valid, pc); end
    halt_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick(1);
    halt_req = 1'b0; redirect = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halted); end
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL halt_redir_pc: got %h expected %h", pc, 32'h40); end
    checks++; if (stage_in_valid !== 4'b1100) begin errors++; $display("FAIL halt_valid0: got %b expected 1100", stage_in_valid); end
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++; if (stage_in_valid !== ev[i]) begin errors++; $display("FAIL halt_drain[%0d]: got %b expected %b", i, stage_in_valid, ev[i]); end
    end
    tick(2);
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL halt_pc_frozen: got %h expected %h", pc, 32'h40); end
    checks++; if (stage_in_valid !== 4'b0000) begin errors++; $display("FAIL halt_empty: got %b expected 0000", stage_in_valid); end
    checks++; if (retire_cnt !== 8'd3) begin errors++; $display("FAIL halt_retire: got %0d expected 3", retire_cnt); end
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL halt_stall: got %0d expected 0", stall_cnt); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", halted); end
    checks++; if (cycle_cnt !== 8'd9) begin errors++; $display("FAIL halt_cycle: got %0d expected 9", cycle_cnt); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL wrap_halt_cleared: got %b expected 0", halted); end
    stage_ready = '1;
    tick(2);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h expected FFFFFFFC", pc); end
    tick(1);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", pc); end
    stage_ready = 5'b11101;
    tick(2);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_stall_pc: got %h expected 0", pc); end
    checks++; if (stall_cnt !== 8'd2) begin errors++; $display("FAIL wrap_stall_cnt: got %0d expected 2", stall_cnt); end
    rst_n = 1'b0;
    tick(1);
    checks++; if (stage_in_valid !== 4'h0) begin errors++; $display("FAIL midreset_valid: got %b expected 0000", stage_in_valid); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL midreset_pc: got %h expected 0", pc); end
    checks++; if ({cycle_cnt, retire_cnt, stall_cnt, flush_cnt} !== 32'h0) begin errors++; $display("FAIL midreset_counters: got %h expected 0", {cycle_cnt, retire_cnt, stall_cnt, flush_cnt}); end
    rst_n = 1'b1;
    stage_ready = '1;
  endtask

  task automatic test_saturate();
    do_reset();
    stage_ready = '1;
    tick(260);
    checks++; if (cycle_cnt !== 8'hFF) begin errors++; $display("FAIL sat_cycle: got %0d expected 255", cycle_cnt); end
    checks++; if (retire_cnt !== 8'hFF) begin errors++; $display("FAIL sat_retire: got %0d expected 255", retire_cnt); end
    checks++; if (pc !== 32'h410) begin errors++; $display("FAIL sat_pc: got %h expected %h", pc, 32'h410); end
  endtask

  initial begin
    stage_ready = '1; redirect = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    test_reset();
    test_fill();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_halt();
    test_wrap_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
